// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction-fetch response block:
// state encodings, bus widths, chip-enable levels and the default NOP word.
package inst_fetch_resp_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [InstBus-1:0] NopInstDefault = 32'h0000_0000;

  typedef enum logic {
    IFR_IDLE = 1'b0,
    IFR_WAIT = 1'b1
  } ifr_state_e;

  function automatic logic word_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_resp_if.sv
// PC-stage / IF-ID / instruction-memory signal bundle for inst_fetch_resp.
// slave = the fetch block's view, master = the environment's view.
interface inst_fetch_resp_if;
  import inst_fetch_resp_pkg::*;

  logic                   ce_i;
  logic [InstAddrBus-1:0] pc_i;
  logic [InstBus-1:0]     inst_o;
  logic                   stallreq_o;
  logic                   fetch_err_o;
  logic                   mem_req_o;
  logic [InstAddrBus-1:0] mem_addr_o;
  logic                   mem_ack_i;
  logic [InstBus-1:0]     mem_rdata_i;

  modport slave (
    input  ce_i, pc_i, mem_ack_i, mem_rdata_i,
    output inst_o, stallreq_o, fetch_err_o, mem_req_o, mem_addr_o
  );

  modport master (
    output ce_i, pc_i, mem_ack_i, mem_rdata_i,
    input  inst_o, stallreq_o, fetch_err_o, mem_req_o, mem_addr_o
  );

endinterface

// File: rtl/inst_fetch_resp_buf_reg.sv
// One-entry instruction buffer (valid/tag/data) with its hit compare.
// The entry is only ever overwritten by a fill; only reset invalidates it.
module inst_buf_reg
  import inst_fetch_resp_pkg::*;
#(
  parameter logic [InstBus-1:0] NOP_INST = NopInstDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fill,
  input  logic [InstAddrBus-1:0] fill_tag,
  input  logic [InstBus-1:0]     fill_data,
  input  logic                   ce,
  input  logic [InstAddrBus-1:0] pc,
  output logic                   hit,
  output logic [InstBus-1:0]     data
);

  logic                   buf_valid;
  logic [InstAddrBus-1:0] buf_tag;
  logic [InstBus-1:0]     buf_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= NOP_INST;
    end else if (fill) begin
      buf_valid <= 1'b1;
      buf_tag   <= fill_tag;
      buf_data  <= fill_data;
    end
  end

  assign hit  = (ce != ChipDisable) && buf_valid && (buf_tag == pc);
  assign data = buf_data;

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch response: one-entry buffer in front of a req/ack instruction memory.
// Optional wait timeout is compiled in with `define IFR_TIMEOUT_EN.
//
// state    | meaning
// IFR_IDLE | no bus transaction; serve hits, issue a request on a miss
// IFR_WAIT | request outstanding at req_addr; wait for ack (or timeout)
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int                 TIMEOUT_CYCLES = 16,
  parameter logic [InstBus-1:0] NOP_INST       = NopInstDefault
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_resp_if.slave   bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("inst_fetch_resp: TIMEOUT_CYCLES must be at least 1");
  end

  ifr_state_e             state, state_nx;
  logic [InstAddrBus-1:0] req_addr;
  logic                   hit, miss, aligned, timeout;
  logic                   fill, mem_req, fetch_err;
  logic [InstAddrBus-1:0] mem_addr;
  logic [InstBus-1:0]     fill_data, buf_data;

  assign aligned = word_aligned(bus.pc_i[1:0]);
  assign miss    = (bus.ce_i == ChipEnable) && aligned && !hit;

`ifdef IFR_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] to_cnt;

  // Held at zero in IDLE so every WAIT episode starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || state == IFR_IDLE) to_cnt <= '0;
    else if (!bus.mem_ack_i)      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state == IFR_WAIT) && !bus.mem_ack_i &&
                   (to_cnt == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IFR_IDLE;
      req_addr <= '0;
    end else begin
      state <= state_nx;
      if (state == IFR_IDLE && miss) req_addr <= bus.pc_i;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_addr  = bus.pc_i;
    fill      = 1'b0;
    fill_data = bus.mem_rdata_i;
    fetch_err = 1'b0;
    case (state)
      IFR_IDLE: begin
        fetch_err = (bus.ce_i == ChipEnable) && !aligned;
        if (miss) begin
          mem_req  = 1'b1;
          state_nx = IFR_WAIT;
        end
      end
      IFR_WAIT: begin
        mem_req  = 1'b1;
        mem_addr = req_addr;
        if (bus.mem_ack_i) begin
          fill     = 1'b1;
          state_nx = IFR_IDLE;
        end else if (timeout) begin
          // Park a NOP under the stuck address so the pipeline can move on.
          fill      = 1'b1;
          fill_data = NOP_INST;
          fetch_err = 1'b1;
          state_nx  = IFR_IDLE;
        end
      end
    endcase
    if (rst) begin
      mem_req   = 1'b0;
      fetch_err = 1'b0;
      fill      = 1'b0;
    end
  end

  inst_buf_reg #(.NOP_INST(NOP_INST)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .fill      (fill),
    .fill_tag  (req_addr),
    .fill_data (fill_data),
    .ce        (bus.ce_i),
    .pc        (bus.pc_i),
    .hit       (hit),
    .data      (buf_data)
  );

  assign bus.stallreq_o  = (miss || state == IFR_WAIT) && (bus.ce_i == ChipEnable);
  assign bus.inst_o      = hit ? buf_data : NOP_INST;
  assign bus.fetch_err_o = fetch_err;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_addr_o  = mem_addr;

endmodule
